memwb_pipe_reg: RTL and testbench
=================================

Name: memwb_pipe_reg

Overview:
Parametrised MEM/WB pipeline register for the 5-stage datapath. It captures the instruction, memory read data and ALU result at the MEM/WB boundary. It adds a valid bit, stall (hold) and flush (bubble insertion), and registers a one-away forwarding value selected by load-opcode decode. It also keeps a wrapping retired-instruction counter for bench and debug visibility.

Parameters:
INSTR_W, 16, instruction width in bits
DATA_W, 16, memory read data width; must satisfy DATA_W <= ALU_W
ALU_W, 32, ALU result width and forwarding bus width
OPC_W, 4, opcode field width; opcode is InstructionIn[INSTR_W-1 -: OPC_W]
LOAD_OPC_A, 4'b0110, first opcode treated as a load
LOAD_OPC_B, 4'b0100, second opcode treated as a load
NOP_INSTR, 0, instruction value driven on flush and reset
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
stall  in  1  hold all registered outputs this cycle
flush  in  1  insert a bubble this cycle; has priority over stall
ValidIn  in  1  MEM-stage instruction valid
InstructionIn  in  INSTR_W  MEM-stage instruction
ReadDataIn  in  DATA_W  data memory read result
ALUResultIn  in  ALU_W  MEM-stage ALU result
ValidOut  out  1  WB-stage instruction valid
InstructionOut  out  INSTR_W  WB-stage instruction
ReadDataOut  out  DATA_W  registered read data
ALUResultOut  out  ALU_W  registered ALU result
IsLoadOut  out  1  registered load decode of the WB instruction
OneAwayForward  out  ALU_W  forwarding value for the EX stage
ForwardValid  out  1  OneAwayForward is usable
RetiredCount  out  CNT_W  count of valid instructions captured

Behaviour:
- All outputs are registered and update only on the rising edge of clk. There is no combinational path from any input to any output.
- is_load (combinational) = ValidIn AND (opcode == LOAD_OPC_A OR opcode == LOAD_OPC_B).
- Priority order per edge: rst > flush > stall > capture.
- rst = 1:
  - ValidOut, IsLoadOut, ForwardValid = 0.
  - InstructionOut = NOP_INSTR.
  - ReadDataOut, ALUResultOut, OneAwayForward, RetiredCount = 0.
- flush = 1 (rst = 0), regardless of stall:
  - ValidOut, IsLoadOut, ForwardValid = 0.
  - InstructionOut = NOP_INSTR.
  - ReadDataOut, ALUResultOut, OneAwayForward = 0.
  - RetiredCount holds.
- stall = 1 (rst = 0, flush = 0): every output holds its value, including RetiredCount.
- Capture (rst = 0, flush = 0, stall = 0):
  - ValidOut <= ValidIn; InstructionOut <= InstructionIn.
  - ReadDataOut <= ReadDataIn; ALUResultOut <= ALUResultIn.
  - IsLoadOut <= is_load.
  - OneAwayForward <= is_load ? zero-extend(ReadDataIn) to ALU_W : ALUResultIn.
  - ForwardValid <= ValidIn.
  - RetiredCount <= RetiredCount + 1 if ValidIn, else it holds.
- Latency: exactly 1 cycle from capture edge to output.
- With ValidIn = 0, data fields are still captured, but ValidOut and ForwardValid are 0. Consumers must gate on ValidOut / ForwardValid.
- RetiredCount wraps modulo 2^CNT_W, from all-ones to 0, with no saturation and no flag.
- Reset asserted mid-stall or mid-flush wins on that edge. The first capture happens on the first edge with rst = 0 and stall = 0.
- Consecutive stall cycles hold indefinitely. Deasserting stall captures the inputs present on that edge.
- A load opcode with ValidIn = 0 is not a load: IsLoadOut = 0 and OneAwayForward = ALUResultIn.
- Elaboration check: DATA_W > ALU_W or OPC_W > INSTR_W is an elaboration error.

Test Plan:
- Reset: rst = 1 for 2 cycles with arbitrary inputs -> ValidOut = 0, InstructionOut = 0x0000, OneAwayForward = 0, RetiredCount = 0.
- Load forward: Valid = 1, Instr = 0x6123, ReadData = 0xBEEF, ALU = 0x00001234 -> next cycle OneAwayForward = 0x0000BEEF, IsLoadOut = 1. Repeat with Instr = 0x4ABC -> same selection.
- ALU forward: Valid = 1, Instr = 0x1123, ALU = 0xDEADBEEF -> OneAwayForward = 0xDEADBEEF, IsLoadOut = 0, RetiredCount increments by 1.
- Stall/flush priority:
  - Capture A, then stall = 1 for 3 cycles with new inputs -> outputs stay at A.
  - Then assert flush = 1 and stall = 1 together -> ValidOut = 0, InstructionOut = NOP_INSTR, RetiredCount unchanged.
- Invalid load: Valid = 0, Instr = 0x6000 -> IsLoadOut = 0, ForwardValid = 0, OneAwayForward = ALUResultIn, RetiredCount unchanged.
- Counter wrap: CNT_W = 4, 17 valid captures -> RetiredCount sequence reaches 0xF, then 0x0, then 0x1.

Source files
------------

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register: captures instruction, read data and ALU result,
// with stall/flush control, load-decoded one-away forwarding and a retired counter.
module memwb_pipe_reg #(
  parameter int                 INSTR_W    = 16,
  parameter int                 DATA_W     = 16,
  parameter int                 ALU_W      = 32,
  parameter int                 OPC_W      = 4,
  parameter logic [OPC_W-1:0]   LOAD_OPC_A = 4'b0110,
  parameter logic [OPC_W-1:0]   LOAD_OPC_B = 4'b0100,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = '0,
  parameter int                 CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               ValidIn,
  input  logic [INSTR_W-1:0] InstructionIn,
  input  logic [DATA_W-1:0]  ReadDataIn,
  input  logic [ALU_W-1:0]   ALUResultIn,
  output logic               ValidOut,
  output logic [INSTR_W-1:0] InstructionOut,
  output logic [DATA_W-1:0]  ReadDataOut,
  output logic [ALU_W-1:0]   ALUResultOut,
  output logic               IsLoadOut,
  output logic [ALU_W-1:0]   OneAwayForward,
  output logic               ForwardValid,
  output logic [CNT_W-1:0]   RetiredCount
);

  generate
    if (DATA_W > ALU_W) begin : g_bad_data_w
      $error("memwb_pipe_reg: DATA_W must not exceed ALU_W");
    end
    if (OPC_W > INSTR_W) begin : g_bad_opc_w
      $error("memwb_pipe_reg: OPC_W must not exceed INSTR_W");
    end
  endgenerate

  logic [OPC_W-1:0] w_opcode;
  logic             w_is_load;
  logic [ALU_W-1:0] w_fwd_sel;

  assign w_opcode  = InstructionIn[INSTR_W-1 -: OPC_W];
  // An invalid slot never counts as a load, so it forwards the ALU result.
  assign w_is_load = ValidIn && ((w_opcode == LOAD_OPC_A) || (w_opcode == LOAD_OPC_B));
  assign w_fwd_sel = w_is_load ? ALU_W'(ReadDataIn) : ALUResultIn;

  logic               r_valid_p1;
  logic [INSTR_W-1:0] r_instr_p1;
  logic [DATA_W-1:0]  r_rdata_p1;
  logic [ALU_W-1:0]   r_alu_p1;
  logic               r_is_load_p1;
  logic [ALU_W-1:0]   r_fwd_p1;
  logic               r_fwd_vld_p1;
  logic [CNT_W-1:0]   r_retired;

  // MEM -> WB boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_p1   <= 1'b0;
      r_instr_p1   <= NOP_INSTR;
      r_rdata_p1   <= '0;
      r_alu_p1     <= '0;
      r_is_load_p1 <= 1'b0;
      r_fwd_p1     <= '0;
      r_fwd_vld_p1 <= 1'b0;
      r_retired    <= '0;
    end else if (flush) begin
      r_valid_p1   <= 1'b0;
      r_instr_p1   <= NOP_INSTR;
      r_rdata_p1   <= '0;
      r_alu_p1     <= '0;
      r_is_load_p1 <= 1'b0;
      r_fwd_p1     <= '0;
      r_fwd_vld_p1 <= 1'b0;
    end else if (!stall) begin
      r_valid_p1   <= ValidIn;
      r_instr_p1   <= InstructionIn;
      r_rdata_p1   <= ReadDataIn;
      r_alu_p1     <= ALUResultIn;
      r_is_load_p1 <= w_is_load;
      r_fwd_p1     <= w_fwd_sel;
      r_fwd_vld_p1 <= ValidIn;
      if (ValidIn) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  assign ValidOut       = r_valid_p1;
  assign InstructionOut = r_instr_p1;
  assign ReadDataOut    = r_rdata_p1;
  assign ALUResultOut   = r_alu_p1;
  assign IsLoadOut      = r_is_load_p1;
  assign OneAwayForward = r_fwd_p1;
  assign ForwardValid   = r_fwd_vld_p1;
  assign RetiredCount   = r_retired;

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Randomized and directed bench for memwb_pipe_reg against a behavioural model;
// a second instance with a 4-bit counter exercises counter wrap.
module tb_memwb_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ValidIn;
  logic [15:0] InstructionIn, ReadDataIn;
  logic [31:0] ALUResultIn;

  logic        ValidOut, IsLoadOut, ForwardValid;
  logic [15:0] InstructionOut, ReadDataOut, RetiredCount;
  logic [31:0] ALUResultOut, OneAwayForward;

  logic        v4_ValidOut, v4_IsLoadOut, v4_ForwardValid;
  logic [15:0] v4_InstructionOut, v4_ReadDataOut;
  logic [31:0] v4_ALUResultOut, v4_OneAwayForward;
  logic [3:0]  v4_RetiredCount;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of what WB should show
  logic        m_valid, m_is_load, m_fwd_vld;
  logic [15:0] m_instr, m_rdata;
  logic [31:0] m_alu, m_fwd;
  int unsigned m_retired;

  always #5 clk = ~clk;

  memwb_pipe_reg u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ValidIn(ValidIn), .InstructionIn(InstructionIn),
    .ReadDataIn(ReadDataIn), .ALUResultIn(ALUResultIn),
    .ValidOut(ValidOut), .InstructionOut(InstructionOut),
    .ReadDataOut(ReadDataOut), .ALUResultOut(ALUResultOut),
    .IsLoadOut(IsLoadOut), .OneAwayForward(OneAwayForward),
    .ForwardValid(ForwardValid), .RetiredCount(RetiredCount)
  );

  memwb_pipe_reg #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ValidIn(ValidIn), .InstructionIn(InstructionIn),
    .ReadDataIn(ReadDataIn), .ALUResultIn(ALUResultIn),
    .ValidOut(v4_ValidOut), .InstructionOut(v4_InstructionOut),
    .ReadDataOut(v4_ReadDataOut), .ALUResultOut(v4_ALUResultOut),
    .IsLoadOut(v4_IsLoadOut), .OneAwayForward(v4_OneAwayForward),
    .ForwardValid(v4_ForwardValid), .RetiredCount(v4_RetiredCount)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit opc_is_load(input logic [15:0] instr);
    return (instr[15:12] == 4'h6) || (instr[15:12] == 4'h4);
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_valid = 0; m_is_load = 0; m_fwd_vld = 0;
      m_instr = 16'h0; m_rdata = 16'h0; m_alu = 32'h0; m_fwd = 32'h0;
      m_retired = 0;
    end else if (flush) begin
      m_valid = 0; m_is_load = 0; m_fwd_vld = 0;
      m_instr = 16'h0; m_rdata = 16'h0; m_alu = 32'h0; m_fwd = 32'h0;
    end else if (!stall) begin
      m_valid   = ValidIn;
      m_instr   = InstructionIn;
      m_rdata   = ReadDataIn;
      m_alu     = ALUResultIn;
      m_is_load = ValidIn && opc_is_load(InstructionIn);
      m_fwd     = m_is_load ? {16'h0, ReadDataIn} : ALUResultIn;
      m_fwd_vld = ValidIn;
      if (ValidIn) m_retired = m_retired + 1;
    end
  endtask

  task automatic compare_all();
    check("valid",   ValidOut,        m_valid);
    check("instr",   InstructionOut,  m_instr);
    check("rdata",   ReadDataOut,     m_rdata);
    check("alu",     ALUResultOut,    m_alu);
    check("is_load", IsLoadOut,       m_is_load);
    check("fwd",     OneAwayForward,  m_fwd);
    check("fwd_vld", ForwardValid,    m_fwd_vld);
    check("retired", RetiredCount,    m_retired % 65536);
    check("ret4",    v4_RetiredCount, m_retired % 16);
    check("fwd4",    v4_OneAwayForward, m_fwd);
  endtask

  // Drive one edge's inputs, clock it, then compare one time unit after the edge.
  task automatic step(input logic r, input logic f, input logic s, input logic v,
                      input logic [15:0] ins, input logic [15:0] rd, input logic [31:0] alu);
    rst = r; flush = f; stall = s; ValidIn = v;
    InstructionIn = ins; ReadDataIn = rd; ALUResultIn = alu;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    logic [15:0] snap_instr;
    logic [15:0] snap_cnt;
    rst = 1; stall = 0; flush = 0; ValidIn = 0;
    InstructionIn = 0; ReadDataIn = 0; ALUResultIn = 0;
    m_valid = 0; m_is_load = 0; m_fwd_vld = 0;
    m_instr = 0; m_rdata = 0; m_alu = 0; m_fwd = 0; m_retired = 0;
    #2;

    // Reset with arbitrary inputs
    step(1, 0, 0, 1, 16'h6123, 16'hAAAA, 32'h55555555);
    step(1, 1, 1, 1, 16'h4FFF, 16'h1234, 32'hFFFFFFFF);
    check("rst_valid", ValidOut, 1'b0);
    check("rst_instr", InstructionOut, 16'h0000);
    check("rst_fwd",   OneAwayForward, 32'h0);
    check("rst_cnt",   RetiredCount, 16'h0);

    // Load forwarding via both load opcodes
    step(0, 0, 0, 1, 16'h6123, 16'hBEEF, 32'h00001234);
    check("ld_a_fwd",  OneAwayForward, 32'h0000BEEF);
    check("ld_a_isld", IsLoadOut, 1'b1);
    step(0, 0, 0, 1, 16'h4ABC, 16'hBEEF, 32'h00001234);
    check("ld_b_fwd",  OneAwayForward, 32'h0000BEEF);
    check("ld_b_isld", IsLoadOut, 1'b1);

    // ALU forwarding
    step(0, 0, 0, 1, 16'h1123, 16'h7777, 32'hDEADBEEF);
    check("alu_fwd",  OneAwayForward, 32'hDEADBEEF);
    check("alu_isld", IsLoadOut, 1'b0);
    check("alu_cnt",  RetiredCount, 16'd3);

    // Capture A, stall three cycles with changing inputs, then flush+stall
    step(0, 0, 0, 1, 16'h2A2A, 16'h0A0A, 32'hA0A0A0A0);
    snap_instr = InstructionOut;
    snap_cnt   = RetiredCount;
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 1, 16'h6000 + 16'(i), 16'(i), 32'(i));
    check("stall_instr", InstructionOut, 16'h2A2A);
    check("stall_cnt",   RetiredCount, snap_cnt);
    step(0, 1, 1, 1, 16'h3333, 16'h3333, 32'h33333333);
    check("flush_valid", ValidOut, 1'b0);
    check("flush_instr", InstructionOut, 16'h0000);
    check("flush_cnt",   RetiredCount, snap_cnt);

    // Load opcode without ValidIn is not a load
    step(0, 0, 0, 0, 16'h6000, 16'hCAFE, 32'h12345678);
    check("inv_isld", IsLoadOut, 1'b0);
    check("inv_fvld", ForwardValid, 1'b0);
    check("inv_fwd",  OneAwayForward, 32'h12345678);
    check("inv_cnt",  RetiredCount, snap_cnt);

    // Counter wrap on the 4-bit instance
    step(1, 0, 0, 0, 16'h0, 16'h0, 32'h0);
    for (int i = 1; i <= 17; i++) begin
      step(0, 0, 0, 1, 16'($urandom), 16'($urandom), $urandom);
      if (i == 15) check("wrap_f", v4_RetiredCount, 4'hF);
      if (i == 16) check("wrap_0", v4_RetiredCount, 4'h0);
      if (i == 17) check("wrap_1", v4_RetiredCount, 4'h1);
    end

    // Randomized traffic with occasional reset, flush and stall
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if ($urandom_range(0, 2) == 0) ins[15:12] = ($urandom_range(0, 1) == 0) ? 4'h6 : 4'h4;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
           ins, 16'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
